// File: rtl/cmp_req_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : cmp_req_sequencer                                                 |
// | Desc    : Sequences compare requests through the compare unit and returns   |
// |           one packed status byte per request. Optional macro: CMP_SWEEP_EN. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module cmp_req_sequencer #(
   parameter int WIDTH_A       = 8,
   parameter int WIDTH_B       = 8,
   parameter int WIDTH_CMP_OUT = 8,
   parameter int OUT_WIDTH     = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     REQ_Valid,
   output logic                     REQ_Ready,
   input  logic [1:0]               REQ_FUN,
   input  logic [WIDTH_A-1:0]       REQ_A,
   input  logic [WIDTH_B-1:0]       REQ_B,
   output logic [1:0]               ALU_FUN,
   output logic [WIDTH_A-1:0]       A,
   output logic [WIDTH_B-1:0]       B,
   output logic                     CMP_Enable,
   input  logic [WIDTH_CMP_OUT-1:0] CMP_OUT,
   input  logic                     CMP_Flag,
   output logic [OUT_WIDTH-1:0]     RES_Data,
   output logic                     RES_Valid,
   input  logic                     RES_Ready
);

   localparam logic [WIDTH_CMP_OUT-1:0] C_CODE_EQ = WIDTH_CMP_OUT'(1);
   localparam logic [WIDTH_CMP_OUT-1:0] C_CODE_GT = WIDTH_CMP_OUT'(2);
   localparam logic [WIDTH_CMP_OUT-1:0] C_CODE_LT = WIDTH_CMP_OUT'(3);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_SEND    = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nx;
   logic                   r_rst_done;
   logic [1:0]             r_req_fun;
   logic [1:0]             r_alu_fun;
   logic [WIDTH_A-1:0]     r_a;
   logic [WIDTH_B-1:0]     r_b;
   logic                   r_cmp_enable;
   logic                   r_res_valid;
   logic [OUT_WIDTH-1:0]   r_res_data;
   logic                   r_eq, r_gt, r_lt, r_err;
   logic                   w_accept;
   logic                   w_sweep_start;
   logic                   w_sweep_more;
   logic                   w_hit_eq, w_hit_gt, w_hit_lt, w_code_err;
   logic                   w_eq_nx, w_gt_nx, w_lt_nx, w_err_nx;
   logic [OUT_WIDTH-1:0]   w_res_byte;

   assign REQ_Ready  = r_rst_done && (r_state == S_IDLE);
   assign w_accept   = REQ_Valid && REQ_Ready;
   assign ALU_FUN    = r_alu_fun;
   assign A          = r_a;
   assign B          = r_b;
   assign CMP_Enable = r_cmp_enable;
   assign RES_Valid  = r_res_valid;
   assign RES_Data   = r_res_data;

`ifdef CMP_SWEEP_EN
   // A sweep walks ALU_FUN through 01, 10, 11 and ORs the hits together.
   logic r_sweep;

   assign w_sweep_start = (REQ_FUN == 2'b00);
   assign w_sweep_more  = r_sweep && (r_alu_fun != 2'b11);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_sweep <= 1'b0;
      end else if (w_accept) begin
         r_sweep <= w_sweep_start;
      end
   end
`else
   assign w_sweep_start = 1'b0;
   assign w_sweep_more  = 1'b0;
`endif

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_state_nx = S_ISSUE;
         S_ISSUE:   w_state_nx = S_CAPTURE;
         S_CAPTURE: w_state_nx = w_sweep_more ? S_ISSUE : S_SEND;
         S_SEND:    if (RES_Ready) w_state_nx = S_IDLE;
         default:   w_state_nx = S_IDLE;
      endcase
   end

   // Only the code that matches the issued function counts as a hit.
   always_comb begin
      w_hit_eq   = (r_alu_fun == 2'b01) && (CMP_OUT == C_CODE_EQ);
      w_hit_gt   = (r_alu_fun == 2'b10) && (CMP_OUT == C_CODE_GT);
      w_hit_lt   = (r_alu_fun == 2'b11) && (CMP_OUT == C_CODE_LT);
      w_code_err = (CMP_OUT != '0) && !(w_hit_eq || w_hit_gt || w_hit_lt);
      w_eq_nx    = r_eq  || w_hit_eq;
      w_gt_nx    = r_gt  || w_hit_gt;
      w_lt_nx    = r_lt  || w_hit_lt;
      w_err_nx   = r_err || w_code_err;
      w_res_byte      = '0;
      w_res_byte[7:0] = {w_err_nx, r_req_fun, 2'b00, w_lt_nx, w_gt_nx, w_eq_nx};
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state      <= S_IDLE;
         r_rst_done   <= 1'b0;
         r_req_fun    <= 2'b00;
         r_alu_fun    <= 2'b00;
         r_a          <= '0;
         r_b          <= '0;
         r_cmp_enable <= 1'b0;
         r_res_valid  <= 1'b0;
         r_res_data   <= '0;
         r_eq         <= 1'b0;
         r_gt         <= 1'b0;
         r_lt         <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_rst_done   <= 1'b1;
         r_state      <= w_state_nx;
         r_cmp_enable <= (w_state_nx == S_ISSUE);
         r_res_valid  <= (w_state_nx == S_SEND);
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_req_fun <= REQ_FUN;
                  r_alu_fun <= w_sweep_start ? 2'b01 : REQ_FUN;
                  r_a       <= REQ_A;
                  r_b       <= REQ_B;
                  r_eq      <= 1'b0;
                  r_gt      <= 1'b0;
                  r_lt      <= 1'b0;
                  r_err     <= 1'b0;
               end
            end
            S_ISSUE: begin
               if (!CMP_Flag) r_err <= 1'b1;
            end
            S_CAPTURE: begin
               r_eq  <= w_eq_nx;
               r_gt  <= w_gt_nx;
               r_lt  <= w_lt_nx;
               r_err <= w_err_nx;
               if (w_sweep_more) begin
                  r_alu_fun <= r_alu_fun + 2'b01;
               end else begin
                  r_res_data <= w_res_byte;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cmp_req_sequencer.sv
`default_nettype none
// Testbench for cmp_req_sequencer: behavioural compare unit plus directed vectors.
module tb_cmp_req_sequencer;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       REQ_Valid = 1'b0;
   logic       REQ_Ready;
   logic [1:0] REQ_FUN = 2'b00;
   logic [7:0] REQ_A = 8'h00;
   logic [7:0] REQ_B = 8'h00;
   logic [1:0] ALU_FUN;
   logic [7:0] A, B;
   logic       CMP_Enable;
   logic [7:0] CMP_OUT;
   logic       CMP_Flag;
   logic [7:0] RES_Data;
   logic       RES_Valid;
   logic       RES_Ready = 1'b1;

   logic       fault_out_en = 1'b0;
   logic [7:0] fault_out_val = 8'h00;
   logic       fault_flag0 = 1'b0;

`ifdef CMP_SWEEP_EN
   localparam bit SWEEP = 1'b1;
`else
   localparam bit SWEEP = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   cmp_req_sequencer dut (
      .CLK(CLK), .RST(RST),
      .REQ_Valid(REQ_Valid), .REQ_Ready(REQ_Ready), .REQ_FUN(REQ_FUN),
      .REQ_A(REQ_A), .REQ_B(REQ_B),
      .ALU_FUN(ALU_FUN), .A(A), .B(B), .CMP_Enable(CMP_Enable),
      .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
      .RES_Data(RES_Data), .RES_Valid(RES_Valid), .RES_Ready(RES_Ready)
   );

   // Registered compare unit: code appears the cycle after the enable strobe.
   function automatic logic [7:0] cmp_model(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
      case (f)
         2'b01:   return (a == b) ? 8'd1 : 8'd0;
         2'b10:   return (a >  b) ? 8'd2 : 8'd0;
         2'b11:   return (a <  b) ? 8'd3 : 8'd0;
         default: return 8'd0;
      endcase
   endfunction

   always @(posedge CLK or negedge RST) begin
      if (!RST)            CMP_OUT <= 8'h00;
      else if (CMP_Enable) CMP_OUT <= fault_out_en ? fault_out_val : cmp_model(ALU_FUN, A, B);
   end
   assign CMP_Flag = fault_flag0 ? 1'b0 : CMP_Enable;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_req(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] d, output int lat, output int ens);
      int guard;
      @(negedge CLK);
      REQ_Valid = 1'b1; REQ_FUN = f; REQ_A = a; REQ_B = b;
      guard = 0;
      while (!REQ_Ready && guard < 20) begin
         @(negedge CLK);
         guard++;
      end
      @(posedge CLK); #1;
      REQ_Valid = 1'b0;
      lat = 1;
      ens = int'(CMP_Enable);
      while (!RES_Valid && lat < 20) begin
         @(posedge CLK); #1;
         lat++;
         ens += int'(CMP_Enable);
      end
      d = RES_Data;
   endtask

   typedef struct {
      logic [1:0] fun;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp;
      int         lat;
      int         ens;
   } vec_t;

   vec_t       vecs[9];
   logic [7:0] d, d0;
   int         lat, ens;

   initial begin
      vecs[0] = '{2'b01, 8'h5A, 8'h5A, 8'h21, 3, 1};
      vecs[1] = '{2'b01, 8'h5A, 8'h5B, 8'h20, 3, 1};
      vecs[2] = '{2'b10, 8'h80, 8'h7F, 8'h42, 3, 1};
      vecs[3] = '{2'b10, 8'h7F, 8'h80, 8'h40, 3, 1};
      vecs[4] = '{2'b11, 8'h03, 8'h09, 8'h64, 3, 1};
      vecs[5] = '{2'b11, 8'h09, 8'h03, 8'h60, 3, 1};
      vecs[6] = '{2'b00, 8'h04, 8'h07, SWEEP ? 8'h04 : 8'h00, SWEEP ? 7 : 3, SWEEP ? 3 : 1};
      vecs[7] = '{2'b00, 8'h33, 8'h33, SWEEP ? 8'h01 : 8'h00, SWEEP ? 7 : 3, SWEEP ? 3 : 1};
      vecs[8] = '{2'b00, 8'h09, 8'h03, SWEEP ? 8'h02 : 8'h00, SWEEP ? 7 : 3, SWEEP ? 3 : 1};

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_req_ready", REQ_Ready, 0);
      chk("rst_res_valid", RES_Valid, 0);
      chk("rst_cmp_enable", CMP_Enable, 0);
      chk("rst_res_data", RES_Data, 0);
      chk("rst_alu_fun", ALU_FUN, 0);
      @(negedge CLK);
      RST = 1'b1;
      #1 chk("rst_done_delay", REQ_Ready, 0);
      @(posedge CLK); #1;
      chk("rst_done_ready", REQ_Ready, 1);

      // Table-driven vectors, downstream always ready
      RES_Ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         run_req(vecs[i].fun, vecs[i].a, vecs[i].b, d, lat, ens);
         chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_enables", i), ens, vecs[i].ens);
         @(posedge CLK); #1;
         chk($sformatf("vec%0d_valid_drop", i), RES_Valid, 0);
      end
      chk("operand_hold_a", A, 8'h09);
      chk("operand_hold_b", B, 8'h03);

      // Backpressure: result held stable, no new request accepted
      @(negedge CLK);
      RES_Ready = 1'b0;
      run_req(2'b10, 8'h80, 8'h7F, d0, lat, ens);
      chk("bp_first_data", d0, 8'h42);
      for (int c = 0; c < 5; c++) begin
         @(posedge CLK); #1;
         chk($sformatf("bp_valid_c%0d", c), RES_Valid, 1);
         chk($sformatf("bp_data_c%0d", c), RES_Data, 8'h42);
         chk($sformatf("bp_req_ready_c%0d", c), REQ_Ready, 0);
      end
      @(negedge CLK);
      RES_Ready = 1'b1;
      @(posedge CLK); #1;
      chk("bp_release_valid", RES_Valid, 0);
      chk("bp_release_req_ready", REQ_Ready, 1);

      // Fault: wrong code for the issued function
      fault_out_en = 1'b1; fault_out_val = 8'd2;
      run_req(2'b01, 8'h11, 8'h22, d, lat, ens);
      chk("fault_code_data", d, 8'hA0);
      @(negedge CLK);
      fault_out_en = 1'b0;

      // Fault: missing enable echo
      fault_flag0 = 1'b1;
      run_req(2'b01, 8'h5A, 8'h5A, d, lat, ens);
      chk("fault_flag_data", d, 8'hA1);
      @(negedge CLK);
      fault_flag0 = 1'b0;
      run_req(2'b11, 8'h03, 8'h09, d, lat, ens);
      chk("post_fault_clean", d, 8'h64);

      // Reset during SEND aborts the result
      @(negedge CLK);
      RES_Ready = 1'b0;
      run_req(2'b01, 8'h5A, 8'h5A, d, lat, ens);
      chk("midrst_pre_valid", RES_Valid, 1);
      #2 RST = 1'b0;
      #1;
      chk("midrst_res_valid", RES_Valid, 0);
      chk("midrst_cmp_enable", CMP_Enable, 0);
      chk("midrst_req_ready", REQ_Ready, 0);
      chk("midrst_res_data", RES_Data, 0);
      @(negedge CLK);
      RST = 1'b1;
      RES_Ready = 1'b1;
      #1 chk("midrst_ready_before_edge", REQ_Ready, 0);
      @(posedge CLK); #1;
      chk("midrst_ready_after_edge", REQ_Ready, 1);
      chk("midrst_no_result", RES_Valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
